// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcodes, responder FSM states.
package cpu_pkg;

    localparam int unsigned INSTR_W = 59;
    localparam int unsigned PC_W    = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NREGS   = 8;
    localparam int unsigned REG_AW  = $clog2(NREGS);
    localparam int unsigned OP_W    = 4;

    localparam int unsigned OPC_LSB = 55;
    localparam int unsigned RD_LSB  = 52;
    localparam int unsigned RS1_LSB = 49;
    localparam int unsigned RS2_LSB = 46;
    localparam int unsigned TGT_LSB = 41;
    localparam int unsigned RSV_LSB = 16;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_LDI  = 4'd6,
        OP_MUL  = 4'd7,
        OP_BEQ  = 4'd8,
        OP_JMP  = 4'd9,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MUL    = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5,
        S_HALTED = 3'd6
    } state_e;

    typedef struct packed {
        opcode_e            op;
        logic [REG_AW-1:0]  rd;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [PC_W-1:0]    target;
        logic [DATA_W-1:0]  imm;
    } instr_t;

    // Opcodes 10..14 are undefined; they run as NOP and flag illegal.
    function automatic logic is_illegal(input opcode_e op);
        return (4'(op) >= 4'd10) && (4'(op) <= 4'd14);
    endfunction

    function automatic logic writes_rd(input opcode_e op);
        return (4'(op) >= 4'(OP_ADD)) && (4'(op) <= 4'(OP_MUL));
    endfunction

    function automatic logic [DATA_W-1:0] alu(input opcode_e op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] imm);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_LDI:  return imm;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/instr_exec_responder_seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, W cycles per product.
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [CNT_W-1:0] r_cnt;

    // Bit 0 is consumed on the start edge so the product is ready after exactly W edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= b[0] ? a : '0;
                r_a     <= a << 1;
                r_b     <= b >> 1;
                r_cnt   <= CNT_W'(1);
                busy    <= 1'b1;
            end else if (busy) begin
                if (r_b[0]) begin
                    product <= product + r_a;
                end
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_exec_responder.sv
// Responder side of the CPU fetch/issue handshake: executes one instruction
// against the 8x16 register file and hands the next PC back to the fetch FSM.
module instr_exec_responder
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic               busy,
    output logic               done,
    output logic               fetch_stage_enable,
    output logic [PC_W-1:0]    next_pc_to_cpu,
    output logic               halted,
    output logic               illegal,
    input  logic [REG_AW-1:0]  dbg_rd_addr,
    output logic [DATA_W-1:0]  dbg_rd_data
);

    state_e             r_state;
    state_e             w_next_state;
    instr_t             r_instr;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_regs [NREGS];
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic [DATA_W-1:0]  r_result;

    logic [DATA_W-1:0]  w_rs1_val;
    logic [DATA_W-1:0]  w_rs2_val;
    logic [DATA_W-1:0]  w_wb_data;
    logic [PC_W-1:0]    w_next_pc;
    logic               w_take_branch;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [DATA_W-1:0]  w_mul_product;
    logic               w_unused;

    assign w_unused = ^{instruction[TGT_LSB-1:RSV_LSB], w_mul_busy};

    assign w_rs1_val     = r_regs[r_instr.rs1];
    assign w_rs2_val     = r_regs[r_instr.rs2];
    assign w_take_branch = (r_instr.op == OP_JMP) ||
                           ((r_instr.op == OP_BEQ) && (r_op_a == r_op_b));
    assign w_next_pc     = w_take_branch ? r_instr.target : r_pc + PC_W'(1);
    assign w_wb_data     = (r_instr.op == OP_MUL) ? w_mul_product : r_result;
    assign dbg_rd_data   = r_regs[dbg_rd_addr];

    seq_multiplier #(
        .W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (w_rs1_val),
        .b       (w_rs2_val),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mul_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_instr.op == OP_MUL) begin
                    w_next_state = S_MUL;
                    w_mul_start  = 1'b1;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC:   w_next_state = S_WB;
            S_MUL: begin
                if (w_mul_done) begin
                    w_next_state = S_WB;
                end
            end
            S_WB:     w_next_state = (r_instr.op == OP_HALT) ? S_HALTED : S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch, operand read, ALU, writeback and PC commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr  <= '0;
            r_pc     <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            illegal  <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_instr.op     <= opcode_e'(instruction[OPC_LSB +: OP_W]);
                r_instr.rd     <= instruction[RD_LSB +: REG_AW];
                r_instr.rs1    <= instruction[RS1_LSB +: REG_AW];
                r_instr.rs2    <= instruction[RS2_LSB +: REG_AW];
                r_instr.target <= instruction[TGT_LSB +: PC_W];
                r_instr.imm    <= instruction[IMM_LSB +: DATA_W];
            end
            if (r_state == S_DECODE) begin
                r_op_a <= w_rs1_val;
                r_op_b <= w_rs2_val;
                if (is_illegal(r_instr.op)) begin
                    illegal <= 1'b1;
                end
            end
            if (r_state == S_EXEC) begin
                r_result <= alu(r_instr.op, r_op_a, r_op_b, r_instr.imm);
            end
            if ((r_state == S_WB) && writes_rd(r_instr.op) && (r_instr.rd != '0)) begin
                r_regs[r_instr.rd] <= w_wb_data;
            end
            if (r_state == S_DONE) begin
                r_pc <= next_pc_to_cpu;
            end
        end
    end

    // Handshake outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy               <= 1'b0;
            done               <= 1'b0;
            fetch_stage_enable <= 1'b0;
            halted             <= 1'b0;
            next_pc_to_cpu     <= '0;
        end else begin
            busy               <= (w_next_state == S_DECODE) || (w_next_state == S_EXEC) ||
                                  (w_next_state == S_MUL)    || (w_next_state == S_WB);
            done               <= (w_next_state == S_DONE) ||
                                  ((r_state == S_WB) && (w_next_state == S_HALTED));
            fetch_stage_enable <= (w_next_state == S_DONE);
            halted             <= (w_next_state == S_HALTED);
            if ((r_state == S_WB) && (w_next_state == S_DONE)) begin
                next_pc_to_cpu <= w_next_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_responder.sv
// Directed bench for instr_exec_responder with hand-computed expectations.
module tb_instr_exec_responder;
    import cpu_pkg::*;

    logic               clk;
    logic               rst;
    logic               start;
    logic [INSTR_W-1:0] instruction;
    logic               busy;
    logic               done;
    logic               fetch_stage_enable;
    logic [PC_W-1:0]    next_pc_to_cpu;
    logic               halted;
    logic               illegal;
    logic [REG_AW-1:0]  dbg_rd_addr;
    logic [DATA_W-1:0]  dbg_rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int g_lat;
    logic g_busy_ok;
    logic g_fse;
    logic g_done_after;

    instr_exec_responder dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .instruction        (instruction),
        .busy               (busy),
        .done               (done),
        .fetch_stage_enable (fetch_stage_enable),
        .next_pc_to_cpu     (next_pc_to_cpu),
        .halted             (halted),
        .illegal            (illegal),
        .dbg_rd_addr        (dbg_rd_addr),
        .dbg_rd_data        (dbg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [REG_AW-1:0] addr,
                           input logic [DATA_W-1:0] exp);
        dbg_rd_addr = addr;
        #1;
        chk(tag, 32'(dbg_rd_data), 32'(exp));
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                              input logic [2:0] rs1, input logic [2:0] rs2,
                                              input logic [4:0] tgt, input logic [15:0] imm);
        return {op, rd, rs1, rs2, tgt, 25'h0A5_5A5A, imm};
    endfunction

    // Issue one instruction; latency is counted in cycles from the sampling edge.
    task automatic run_instr(input logic [INSTR_W-1:0] ins);
        int n;
        logic seen;
        @(negedge clk);
        start = 1'b1;
        instruction = ins;
        @(posedge clk); #1;
        start = 1'b0;
        g_busy_ok = busy;
        n = 1;
        seen = done;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            seen = done;
            if (!seen && !busy) g_busy_ok = 1'b0;
        end
        g_lat = seen ? n : -1;
        g_fse = fetch_stage_enable;
        @(posedge clk); #1;
        g_done_after = done;
    endtask

    initial begin
        logic seen_bad;
        rst = 1'b0;
        start = 1'b0;
        instruction = '0;
        dbg_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fse", 32'(fetch_stage_enable), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_npc", 32'(next_pc_to_cpu), 0);
        @(negedge clk);
        rst = 1'b1;

        run_instr(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 5'd0, 16'h1234));
        chk("ldi_busy_next", 32'(g_busy_ok), 1);
        chk("ldi_lat", 32'(g_lat), 4);
        chk("ldi_fse", 32'(g_fse), 1);
        chk("ldi_done_1cyc", 32'(g_done_after), 0);
        chk("ldi_npc", 32'(next_pc_to_cpu), 1);
        chk_reg("ldi_r1", 3'd1, 16'h1234);

        run_instr(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 5'd0, 16'hFFFF));
        run_instr(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 5'd0, 16'h0002));
        run_instr(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 5'd0, 16'h0000));
        chk("add_lat", 32'(g_lat), 4);
        chk_reg("add_wrap_r3", 3'd3, 16'h0001);
        chk("add_npc", 32'(next_pc_to_cpu), 4);

        run_instr(mk(OP_MUL, 3'd4, 3'd1, 3'd2, 5'd0, 16'h0000));
        chk("mul_lat", 32'(g_lat), 19);
        chk("mul_busy_held", 32'(g_busy_ok), 1);
        chk("mul_fse", 32'(g_fse), 1);
        chk_reg("mul_r4", 3'd4, 16'hFFFE);
        chk("mul_npc", 32'(next_pc_to_cpu), 5);

        run_instr(mk(OP_SUB, 3'd5, 3'd2, 3'd1, 5'd0, 16'h0000));
        chk_reg("sub_r5", 3'd5, 16'h0003);
        run_instr(mk(OP_AND, 3'd6, 3'd1, 3'd2, 5'd0, 16'h0000));
        chk_reg("and_r6", 3'd6, 16'h0002);
        run_instr(mk(OP_OR, 3'd7, 3'd3, 3'd2, 5'd0, 16'h0000));
        chk_reg("or_r7", 3'd7, 16'h0003);
        run_instr(mk(OP_XOR, 3'd6, 3'd1, 3'd3, 5'd0, 16'h0000));
        chk_reg("xor_r6", 3'd6, 16'hFFFE);
        chk("alu_npc", 32'(next_pc_to_cpu), 9);

        run_instr(mk(OP_BEQ, 3'd0, 3'd0, 3'd0, 5'd20, 16'h0000));
        chk("beq_taken_npc", 32'(next_pc_to_cpu), 20);
        run_instr(mk(OP_BEQ, 3'd0, 3'd1, 3'd0, 5'd20, 16'h0000));
        chk("beq_nt_npc", 32'(next_pc_to_cpu), 21);
        run_instr(mk(OP_JMP, 3'd0, 3'd0, 3'd0, 5'd31, 16'h0000));
        chk("jmp31_npc", 32'(next_pc_to_cpu), 31);
        run_instr(mk(OP_JMP, 3'd0, 3'd0, 3'd0, 5'd5, 16'h0000));
        chk("jmp5_at31_npc", 32'(next_pc_to_cpu), 5);
        run_instr(mk(OP_JMP, 3'd0, 3'd0, 3'd0, 5'd31, 16'h0000));
        run_instr(mk(OP_NOP, 3'd0, 3'd0, 3'd0, 5'd9, 16'h0000));
        chk("nop_wrap_npc", 32'(next_pc_to_cpu), 0);

        run_instr(mk(4'd12, 3'd1, 3'd2, 3'd2, 5'd9, 16'h0055));
        chk("illegal_set", 32'(illegal), 1);
        chk("illegal_npc", 32'(next_pc_to_cpu), 1);
        chk_reg("illegal_r1_kept", 3'd1, 16'hFFFF);
        run_instr(mk(OP_NOP, 3'd0, 3'd0, 3'd0, 5'd0, 16'h0000));
        chk("illegal_sticky", 32'(illegal), 1);
        run_instr(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 5'd0, 16'h0055));
        chk_reg("ldi_r0_zero", 3'd0, 16'h0000);
        chk("ldi_r0_npc", 32'(next_pc_to_cpu), 3);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1;
        instruction = mk(OP_MUL, 3'd4, 3'd1, 3'd2, 5'd0, 16'h0000);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_fse", 32'(fetch_stage_enable), 0);
        chk("mrst_illegal", 32'(illegal), 0);
        chk("mrst_npc", 32'(next_pc_to_cpu), 0);
        chk_reg("mrst_r1", 3'd1, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        run_instr(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 5'd0, 16'h1234));
        chk("post_rst_lat", 32'(g_lat), 4);
        chk("post_rst_npc", 32'(next_pc_to_cpu), 1);
        chk_reg("post_rst_r1", 3'd1, 16'h1234);
        chk_reg("post_rst_r4", 3'd4, 16'h0000);

        run_instr(mk(OP_HALT, 3'd0, 3'd0, 3'd0, 5'd17, 16'h0000));
        chk("halt_lat", 32'(g_lat), 4);
        chk("halt_fse", 32'(g_fse), 0);
        chk("halt_done_1cyc", 32'(g_done_after), 0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_npc", 32'(next_pc_to_cpu), 1);
        @(negedge clk);
        start = 1'b1;
        instruction = mk(OP_LDI, 3'd2, 3'd0, 3'd0, 5'd0, 16'hBEEF);
        seen_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (busy || done || fetch_stage_enable || !halted) seen_bad = 1'b1;
        end
        start = 1'b0;
        chk("halt_ignores_start", 32'(seen_bad), 0);
        chk_reg("halt_r2_kept", 3'd2, 16'h0000);
        chk("halt_npc_kept", 32'(next_pc_to_cpu), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
